// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- UART 8N1 transmitter with a small byte FIFO in front of it.
//
// The host writes bytes into a circular FIFO. Each byte goes out LSB-first
// with a start bit (0), eight data bits and a stop bit (1). Every bit is held
// on the line for TICK clock cycles. Frames follow each other with no idle
// gap while the FIFO still holds data.
//
// Parameters
//   TICK     clock cycles per bit (SYS_FREQ/BAUDRATE), legal range 2..511
//   FIFO_AW  FIFO address width; the FIFO holds 2**FIFO_AW bytes
//
// Ports
//   i_clk    system clock; all logic runs on the rising edge
//   i_reset  synchronous, active-high reset; aborts any frame in flight
//   i_dat    byte to transmit, captured only in a cycle where it is pushed
//   i_wr     write strobe; pushes i_dat when the FIFO is not full
//   o_full   FIFO holds 2**FIFO_AW bytes; a write in this cycle is dropped
//   o_busy   FIFO non-empty or a frame is in progress
//   tx       registered serial output, idle high
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int TICK    = 21,
  parameter int FIFO_AW = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_dat,
  input  logic       i_wr,
  output logic       o_full,
  output logic       o_busy,
  output logic       tx
);

  localparam int DEPTH = 2 ** FIFO_AW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;

  // Transmit side
  state_t     state_q;
  logic [8:0] cnt_q;
  logic [2:0] bit_idx_q;
  logic [7:0] shreg_q;
  logic       tx_q;

  logic       fifo_empty;
  logic       bit_end;
  logic       push;
  logic       pop;
  logic [7:0] head;

  assign fifo_empty = (count_q == '0);
  assign o_full     = (count_q == (FIFO_AW + 1)'(DEPTH));
  assign o_busy     = !fifo_empty || (state_q != S_IDLE);
  assign tx         = tx_q;

  assign bit_end = (cnt_q == 9'(TICK - 1));
  assign head    = mem_q[rd_ptr_q];

  // A write is judged against the pre-edge count, so a full FIFO drops the
  // write even when the transmitter pops in the same cycle.
  assign push = i_wr && !o_full;

  // A byte is taken either from idle or on the last cycle of a stop bit;
  // the latter is what chains frames without an idle gap.
  assign pop = !fifo_empty &&
               ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; only the pointers and count define its contents.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_dat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Transmit state machine. The baud counter restarts at zero at every bit
  // boundary, so each bit occupies exactly TICK cycles.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q  <= 1'b1;
          cnt_q <= '0;
          if (pop) begin
            shreg_q <= head;
            state_q <= S_START;
            tx_q    <= 1'b0;
          end
        end

        S_START: begin
          if (bit_end) begin
            cnt_q     <= '0;
            state_q   <= S_DATA;
            bit_idx_q <= '0;
            tx_q      <= shreg_q[0];
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_idx_q != 3'd7) begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shreg_q[bit_idx_q + 3'd1];
            end else begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (pop) begin
              shreg_q <= head;
              state_q <= S_START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx.
//
// Two instances run side by side from the same stimulus: one at TICK=21 and
// one at TICK=2. A behavioural model (a byte queue plus a "cycles left in the
// current frame" counter per instance) predicts tx, o_busy and o_full for
// every cycle; outputs are compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_tx;

  localparam int TICK_A = 21;
  localparam int TICK_B = 2;
  localparam int DEPTH  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic [7:0] dat;
  logic       full_a, busy_a, tx_a;
  logic       full_b, busy_b, tx_b;

  always #5 clk = ~clk;

  uart_tx #(.TICK(TICK_A), .FIFO_AW(2)) dut_a (
    .i_clk   (clk),
    .i_reset (rst),
    .i_dat   (dat),
    .i_wr    (wr),
    .o_full  (full_a),
    .o_busy  (busy_a),
    .tx      (tx_a)
  );

  uart_tx #(.TICK(TICK_B), .FIFO_AW(2)) dut_b (
    .i_clk   (clk),
    .i_reset (rst),
    .i_dat   (dat),
    .i_wr    (wr),
    .o_full  (full_b),
    .o_busy  (busy_b),
    .tx      (tx_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, index 0 = TICK_A instance, 1 = TICK_B instance.
  logic [7:0] mq [2][$];
  int         frame_left [2];
  logic [7:0] cur [2];
  int         tick_of [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Expected line level: position within a 10-bit frame picks the bit.
  function automatic logic exp_tx(input int k);
    int p;
    int b;
    if (frame_left[k] == 0) return 1'b1;
    p = 10 * tick_of[k] - frame_left[k];
    b = p / tick_of[k];
    if (b == 0) return 1'b0;
    if (b <= 8) return cur[k][b-1];
    return 1'b1;
  endfunction

  function automatic logic model_busy(input int k);
    return (mq[k].size() > 0) || (frame_left[k] > 0);
  endfunction

  task automatic check_outputs();
    check_val("tx_t21",   {31'd0, tx_a},   {31'd0, exp_tx(0)});
    check_val("busy_t21", {31'd0, busy_a}, {31'd0, model_busy(0)});
    check_val("full_t21", {31'd0, full_a}, {31'd0, (mq[0].size() == DEPTH)});
    check_val("tx_t2",    {31'd0, tx_b},   {31'd0, exp_tx(1)});
    check_val("busy_t2",  {31'd0, busy_b}, {31'd0, model_busy(1)});
    check_val("full_t2",  {31'd0, full_b}, {31'd0, (mq[1].size() == DEPTH)});
  endtask

  // Advance the model across one rising edge using the inputs of this cycle.
  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      logic full_pre;
      logic pop_now;
      full_pre = (mq[k].size() == DEPTH);
      if (rst) begin
        mq[k].delete();
        frame_left[k] = 0;
      end else begin
        // Next byte starts from idle, or straight out of the last stop cycle.
        pop_now = (mq[k].size() > 0) && (frame_left[k] <= 1);
        if (frame_left[k] > 0) frame_left[k]--;
        if (pop_now) begin
          cur[k]        = mq[k].pop_front();
          frame_left[k] = 10 * tick_of[k];
        end
        if (wr && !full_pre) mq[k].push_back(dat);
      end
    end
  endtask

  task automatic cycle();
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b);
    dat = b;
    wr  = 1'b1;
    cycle();
    wr  = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((model_busy(0) || model_busy(1)) && g < 20000) begin
      cycle();
      g++;
    end
    check_val("drain_bound", {31'd0, (g >= 20000)}, 32'd0);
    repeat (3) cycle();
  endtask

  initial begin
    tick_of[0]    = TICK_A;
    tick_of[1]    = TICK_B;
    frame_left[0] = 0;
    frame_left[1] = 0;
    cur[0]        = '0;
    cur[1]        = '0;
    rst = 1'b1;
    wr  = 1'b0;
    dat = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    check_val("rst_tx",   {31'd0, tx_a},   32'd1);
    check_val("rst_full", {31'd0, full_a}, 32'd0);
    check_val("rst_busy", {31'd0, busy_a}, 32'd0);
    check_val("rst_tx_b", {31'd0, tx_b},   32'd1);
    rst = 1'b0;
    repeat (3) cycle();

    // Single byte from idle
    write_byte(8'h55);
    check_val("t1_busy_after_write", {31'd0, busy_a}, 32'd1);
    drain();
    $display("T1: 0x55 single frame done");

    // Six back-to-back writes: the sixth sees a full FIFO and is dropped
    for (int i = 0; i < 6; i++) begin
      dat = 8'hA0 + 8'(i);
      wr  = 1'b1;
      if (i == 5) check_val("t2_full_on_a5", {31'd0, full_a}, 32'd1);
      cycle();
    end
    wr = 1'b0;
    drain();
    $display("T2: burst A0..A5 done");

    // Randomized writes, including writes while full
    for (int i = 0; i < 4000; i++) begin
      dat = 8'($urandom_range(0, 255));
      wr  = ($urandom_range(0, 3) == 0);
      cycle();
    end
    wr = 1'b0;
    drain();
    $display("T3: random stream done");

    // Reset in the middle of data bit 3 with two bytes queued
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    begin
      int g;
      g = 0;
      while (frame_left[0] != 10 * TICK_A - (4 * TICK_A + 5) && g < 1000) begin
        cycle();
        g++;
      end
      check_val("t4_reach_bit3", {31'd0, (g >= 1000)}, 32'd0);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_val("t4_tx_after_rst",   {31'd0, tx_a},   32'd1);
    check_val("t4_busy_after_rst", {31'd0, busy_a}, 32'd0);
    repeat (300) cycle();
    write_byte(8'h3C);
    drain();
    $display("T4: mid-frame reset and 0x3C done");

    // 0xFF, 0x00 and enough further bytes to wrap the FIFO pointers
    write_byte(8'hFF);
    write_byte(8'h00);
    for (int i = 0; i < 5; i++) write_byte(8'h10 + 8'(i));
    drain();
    $display("T5: FF/00 and pointer wrap done");

    // Write during the stop bit of the last queued byte
    write_byte(8'h81);
    begin
      int g;
      g = 0;
      while (frame_left[0] != 10 && g < 1000) begin
        cycle();
        g++;
      end
      check_val("t6_reach_stop", {31'd0, (g >= 1000)}, 32'd0);
    end
    write_byte(8'h7E);
    drain();
    $display("T6: write during stop done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
